// File: rtl/types_pkg.sv
// Shared flit types for the router/packetizer/depacketizer family.
package types;

    localparam int MAX_LEN    = 63;
    localparam int SEQ_WIDTH  = $clog2(MAX_LEN + 1);
    localparam int FLIT_WIDTH = 64;

    typedef logic [7:0] node_id_t;

    typedef enum logic [1:0] {
        NOPE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t            ftype;
        node_id_t              src;
        node_id_t              dst;
        logic [SEQ_WIDTH-1:0]  seq;
        logic [31:0]           payload;
        logic [7:0]            checksum;
    } flit_t;

    // XOR of the four payload bytes; used by every endpoint that checks flits.
    function automatic logic [7:0] calc_checksum(input logic [31:0] payload);
        return payload[31:24] ^ payload[23:16] ^ payload[15:8] ^ payload[7:0];
    endfunction

    // Assemble a complete flit, filling in the checksum.
    function automatic flit_t make_flit(input flit_type_t ftype, input node_id_t src,
                                        input node_id_t dst, input logic [SEQ_WIDTH-1:0] seq,
                                        input logic [31:0] payload);
        flit_t f;
        f.ftype    = ftype;
        f.src      = src;
        f.dst      = dst;
        f.seq      = seq;
        f.payload  = payload;
        f.checksum = calc_checksum(payload);
        return f;
    endfunction

endpackage

// File: rtl/flit_packetizer_if.sv
// CPU request/data channels and the router-facing flit link of the packetizer.
interface flit_packetizer_if;
    import types::*;

    node_id_t                node_id;
    logic                    cpu_req_valid;
    logic                    cpu_req_ready;
    node_id_t                cpu_req_dst;
    logic [SEQ_WIDTH-1:0]    cpu_req_len;
    logic                    cpu_data_valid;
    logic                    cpu_data_ready;
    logic [31:0]             cpu_data;
    flit_t                   flit_out;
    logic                    flit_out_valid;
    logic                    flit_out_ready;
    logic [FLIT_WIDTH-1:0]   head_flit_out;
    logic                    err_len_zero;
    logic                    busy;

    // Packetizer side.
    modport slave (
        input  node_id, cpu_req_valid, cpu_req_dst, cpu_req_len,
               cpu_data_valid, cpu_data, flit_out_ready,
        output cpu_req_ready, cpu_data_ready, flit_out, flit_out_valid,
               head_flit_out, err_len_zero, busy
    );

    // CPU + router side.
    modport master (
        output node_id, cpu_req_valid, cpu_req_dst, cpu_req_len,
               cpu_data_valid, cpu_data, flit_out_ready,
        input  cpu_req_ready, cpu_data_ready, flit_out, flit_out_valid,
               head_flit_out, err_len_zero, busy
    );

endinterface

// File: rtl/flit_packetizer.sv
// Turns one (dst, len) request plus len payload words into HEAD, BODY..., TAIL flits.
module flit_packetizer
    import types::*;
(
    input  logic               nocclk,
    input  logic               rst,
    flit_packetizer_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_t;

    state_t                state;
    flit_t                 out_q;
    flit_t                 head_q;
    logic                  out_vld;
    node_id_t              dst_q;
    logic [SEQ_WIDTH-1:0]  len_q;
    logic [SEQ_WIDTH-1:0]  seq_q;      // seq of the last flit loaded into out_q
    logic [SEQ_WIDTH-1:0]  seq_nxt;
    logic [7:0]            pkt_id;
    logic                  err_q;
    logic                  req_rdy;
    logic                  data_rdy;
    logic                  data_fire;
    logic                  out_fire;

    // Handshake qualifiers; the output register can refill in the cycle it drains.
    always_comb begin
        req_rdy   = (state == S_IDLE) && !rst;
        data_rdy  = (state != S_IDLE) && !rst && (seq_q != len_q) &&
                    (!out_vld || bus.flit_out_ready);
        data_fire = data_rdy && bus.cpu_data_valid;
        out_fire  = out_vld && bus.flit_out_ready;
        seq_nxt   = seq_q + 1'b1;
    end

    // Packet FSM with the inline output register.
    always_ff @(posedge nocclk) begin
        if (rst) begin
            state   <= S_IDLE;
            out_q   <= '0;
            head_q  <= '0;
            out_vld <= 1'b0;
            dst_q   <= '0;
            len_q   <= '0;
            seq_q   <= '0;
            pkt_id  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cpu_req_valid) begin
                        if (bus.cpu_req_len == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            out_q   <= make_flit(HEAD, bus.node_id, bus.cpu_req_dst, '0,
                                                 {pkt_id, bus.cpu_req_len, 18'b0});
                            head_q  <= make_flit(HEAD, bus.node_id, bus.cpu_req_dst, '0,
                                                 {pkt_id, bus.cpu_req_len, 18'b0});
                            out_vld <= 1'b1;
                            dst_q   <= bus.cpu_req_dst;
                            len_q   <= bus.cpu_req_len;
                            seq_q   <= '0;
                            state   <= S_HEAD;
                        end
                    end
                end
                S_HEAD, S_BODY: begin
                    if (data_fire) begin
                        out_q   <= make_flit((seq_nxt == len_q) ? TAIL : BODY,
                                             bus.node_id, dst_q, seq_nxt, bus.cpu_data);
                        out_vld <= 1'b1;
                        seq_q   <= seq_nxt;
                    end else if (out_fire) begin
                        out_vld <= 1'b0;
                    end
                    if (state == S_HEAD && out_fire)
                        state <= S_BODY;
                    if (state == S_BODY && out_fire && out_q.ftype == TAIL) begin
                        pkt_id <= pkt_id + 8'd1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_req_ready  = req_rdy;
    assign bus.cpu_data_ready = data_rdy;
    assign bus.flit_out       = out_q;
    assign bus.flit_out_valid = out_vld;
    assign bus.head_flit_out  = head_q;
    assign bus.err_len_zero   = err_q;
    assign bus.busy           = (state != S_IDLE);

endmodule

// File: tb/tb_flit_packetizer.sv
// Randomized bench for flit_packetizer with a packet-level reference model.
module tb_flit_packetizer;

    logic nocclk = 1'b0;
    logic rst;
    always #5 nocclk = ~nocclk;

    flit_packetizer_if bus();

    flit_packetizer dut (
        .nocclk (nocclk),
        .rst    (rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int          model_pkt;
    logic [31:0] words_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int          stab_viol, drdy_viol, rrdy_viol, span;
    bit          req_ok;

    // Reference packet: flit k=0 is the head, k=len is the tail.
    function automatic void ref_packet(input logic [7:0] dst, input int len);
        logic [31:0] p;
        logic [1:0]  t;
        exp_q.delete();
        for (int k = 0; k <= len; k++) begin
            if (k == 0) begin
                t = 2'd1;
                p = {model_pkt[7:0], len[5:0], 18'b0};
            end else begin
                t = (k == len) ? 2'd3 : 2'd2;
                p = words_q[k-1];
            end
            exp_q.push_back({t, bus.node_id, dst, k[5:0], p,
                             p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0]});
        end
        model_pkt = (model_pkt + 1) % 256;
    endfunction

    function automatic void gen_words(input int len);
        words_q.delete();
        for (int k = 0; k < len; k++) words_q.push_back($urandom);
    endfunction

    task automatic do_reset();
        bus.cpu_req_valid  = 1'b0;
        bus.cpu_data_valid = 1'b0;
        bus.flit_out_ready = 1'b0;
        rst = 1'b1;
        @(posedge nocclk);
        @(posedge nocclk);
        #1;
        rst = 1'b0;
        model_pkt = 0;
    endtask

    // Issue one request and run the link until len+1 flits were seen (or abort_after flits).
    // rmode: 0 ready always, 1 ready toggles 1010..., 2 ready random 60%.
    task automatic send_packet(input logic [7:0] dst, input logic [5:0] len, input int rmode,
                               input int dv_pct, input int abort_after);
        int          n, wi, cyc, first_c, last_c;
        logic        rdy, prev_stall;
        logic [63:0] prev;
        obs_q.delete();
        stab_viol = 0; drdy_viol = 0; rrdy_viol = 0; req_ok = 0;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_dst   = dst;
        bus.cpu_req_len   = len;
        for (int c = 0; c < 20 && !req_ok; c++) begin
            #1;
            if (bus.cpu_req_ready) req_ok = 1;
            @(posedge nocclk);
            #1;
        end
        bus.cpu_req_valid = 1'b0;
        if (!req_ok) return;
        ref_packet(dst, int'(len));
        n = int'(len) + 1;
        wi = 0; cyc = 0; first_c = 0; last_c = 0; prev_stall = 0; prev = '0;
        while (obs_q.size() < n && cyc < 4000 &&
               !(abort_after > 0 && obs_q.size() >= abort_after)) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = ($urandom_range(99) < 60);
            endcase
            bus.flit_out_ready = rdy;
            bus.cpu_data_valid = (wi < int'(len)) && ($urandom_range(99) < dv_pct);
            bus.cpu_data       = (wi < int'(len)) ? words_q[wi] : $urandom;
            #1;
            if (prev_stall && (!bus.flit_out_valid || bus.flit_out !== prev)) stab_viol++;
            if (bus.flit_out_valid && !rdy && bus.cpu_data_ready) drdy_viol++;
            if (bus.cpu_req_ready) rrdy_viol++;
            if (bus.cpu_data_valid && bus.cpu_data_ready) wi++;
            if (bus.flit_out_valid && rdy) begin
                obs_q.push_back(bus.flit_out);
                if (obs_q.size() == 1) first_c = cyc;
                last_c = cyc;
            end
            prev_stall = bus.flit_out_valid && !rdy;
            prev       = bus.flit_out;
            @(posedge nocclk);
            #1;
            cyc++;
        end
        bus.cpu_data_valid = 1'b0;
        bus.flit_out_ready = 1'b0;
        span = last_c - first_c;
    endtask

    task automatic test_reset();
        bus.node_id = 8'h01;
        do_reset();
        rst = 1'b1;
        @(posedge nocclk);
        #1;
        n_cmp++; if (bus.flit_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.flit_out_valid); end
        n_cmp++; if (bus.flit_out !== 64'h0) begin n_bad++; $display("FAIL rst_flit: got %h want 0", bus.flit_out); end
        n_cmp++; if (bus.head_flit_out !== 64'h0) begin n_bad++; $display("FAIL rst_head: got %h want 0", bus.head_flit_out); end
        n_cmp++; if (bus.err_len_zero !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.err_len_zero); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.cpu_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", bus.cpu_req_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_req_ready: got %b want 1", bus.cpu_req_ready); end
    endtask

    task automatic test_len_zero();
        bus.cpu_data_valid = 1'b1;
        bus.cpu_data       = 32'hDEAD_BEEF;
        bus.cpu_req_valid  = 1'b1;
        bus.cpu_req_dst    = 8'h22;
        bus.cpu_req_len    = 6'd0;
        #1;
        n_cmp++; if (bus.cpu_data_ready !== 1'b0) begin n_bad++; $display("FAIL idle_data_ready: got %b want 0", bus.cpu_data_ready); end
        @(posedge nocclk);
        #1;
        bus.cpu_req_valid  = 1'b0;
        bus.cpu_data_valid = 1'b0;
        n_cmp++; if (bus.err_len_zero !== 1'b1) begin n_bad++; $display("FAIL len0_err: got %b want 1", bus.err_len_zero); end
        n_cmp++; if (bus.flit_out_valid !== 1'b0) begin n_bad++; $display("FAIL len0_valid: got %b want 0", bus.flit_out_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL len0_busy: got %b want 0", bus.busy); end
        @(posedge nocclk);
        #1;
        n_cmp++; if (bus.err_len_zero !== 1'b0) begin n_bad++; $display("FAIL len0_err_pulse: got %b want 0", bus.err_len_zero); end
        n_cmp++; if (bus.flit_out_valid !== 1'b0) begin n_bad++; $display("FAIL len0_valid2: got %b want 0", bus.flit_out_valid); end
        gen_words(2);
        send_packet(8'h33, 6'd2, 0, 100, 0);
        n_cmp++; if (obs_q.size() !== 3) begin n_bad++; $display("FAIL len0_next_count: got %0d want 3", obs_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [63:0] act;
            act = (k < obs_q.size()) ? obs_q[k] : 'x;
            n_cmp++; if (act !== exp_q[k]) begin n_bad++; $display("FAIL len0_next_flit%0d: got %h want %h", k, act, exp_q[k]); end
        end
        if (obs_q.size() > 0) begin
            n_cmp++; if (obs_q[0][39:32] !== 8'h00) begin n_bad++; $display("FAIL len0_pkt_id: got %h want 00", obs_q[0][39:32]); end
        end
    endtask

    task automatic test_basic();
        do_reset();
        words_q = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
        send_packet(8'h05, 6'd3, 0, 100, 0);
        n_cmp++; if (req_ok !== 1'b1) begin n_bad++; $display("FAIL basic_req: got %b want 1", req_ok); end
        n_cmp++; if (obs_q.size() !== 4) begin n_bad++; $display("FAIL basic_count: got %0d want 4", obs_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [63:0] act;
            act = (k < obs_q.size()) ? obs_q[k] : 'x;
            n_cmp++; if (act !== exp_q[k]) begin n_bad++; $display("FAIL basic_flit%0d: got %h want %h", k, act, exp_q[k]); end
        end
        n_cmp++; if (span !== 3) begin n_bad++; $display("FAIL basic_back_to_back: got span %0d want 3", span); end
        n_cmp++; if (bus.head_flit_out !== exp_q[0]) begin n_bad++; $display("FAIL basic_head_out: got %h want %h", bus.head_flit_out, exp_q[0]); end
        if (obs_q.size() == 4) begin
            n_cmp++; if (obs_q[3][7:0] !== 8'h00) begin n_bad++; $display("FAIL basic_tail_chk: got %h want 00", obs_q[3][7:0]); end
        end
        n_cmp++; if (rrdy_viol !== 0) begin n_bad++; $display("FAIL basic_req_ready_busy: got %0d want 0", rrdy_viol); end
        #1;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_bad++; $display("FAIL basic_req_ready_after: got %b want 1", bus.cpu_req_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_stall();
        do_reset();
        words_q = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
        send_packet(8'h05, 6'd3, 1, 100, 0);
        n_cmp++; if (obs_q.size() !== 4) begin n_bad++; $display("FAIL stall_count: got %0d want 4", obs_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [63:0] act;
            act = (k < obs_q.size()) ? obs_q[k] : 'x;
            n_cmp++; if (act !== exp_q[k]) begin n_bad++; $display("FAIL stall_flit%0d: got %h want %h", k, act, exp_q[k]); end
        end
        n_cmp++; if (stab_viol !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d want 0", stab_viol); end
        n_cmp++; if (drdy_viol !== 0) begin n_bad++; $display("FAIL stall_data_ready: got %0d want 0", drdy_viol); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int p = 0; p < 257; p++) begin
            gen_words(1);
            send_packet(8'($urandom), 6'd1, 0, 100, 0);
            n_cmp++; if (obs_q.size() !== 2) begin n_bad++; $display("FAIL wrap_count p%0d: got %0d want 2", p, obs_q.size()); end
            for (int k = 0; k < exp_q.size(); k++) begin
                logic [63:0] act;
                act = (k < obs_q.size()) ? obs_q[k] : 'x;
                n_cmp++; if (act !== exp_q[k]) begin n_bad++; $display("FAIL wrap_flit p%0d k%0d: got %h want %h", p, k, act, exp_q[k]); end
            end
        end
        if (obs_q.size() > 0) begin
            n_cmp++; if (obs_q[0][39:32] !== 8'h00) begin n_bad++; $display("FAIL wrap_pkt_id: got %h want 00", obs_q[0][39:32]); end
        end
    endtask

    task automatic test_reset_mid();
        gen_words(5);
        send_packet(8'h44, 6'd5, 0, 100, 3);
        n_cmp++; if (obs_q.size() !== 3) begin n_bad++; $display("FAIL midrst_pre_count: got %0d want 3", obs_q.size()); end
        for (int k = 0; k < 3; k++) begin
            logic [63:0] act;
            act = (k < obs_q.size()) ? obs_q[k] : 'x;
            n_cmp++; if (act !== exp_q[k]) begin n_bad++; $display("FAIL midrst_pre_flit%0d: got %h want %h", k, act, exp_q[k]); end
        end
        rst = 1'b1;
        @(posedge nocclk);
        #1;
        rst = 1'b0;
        model_pkt = 0;
        #1;
        n_cmp++; if (bus.flit_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", bus.flit_out_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.head_flit_out !== 64'h0) begin n_bad++; $display("FAIL midrst_head: got %h want 0", bus.head_flit_out); end
        n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_req_ready: got %b want 1", bus.cpu_req_ready); end
        gen_words(2);
        send_packet(8'h55, 6'd2, 0, 100, 0);
        n_cmp++; if (obs_q.size() !== 3) begin n_bad++; $display("FAIL midrst_next_count: got %0d want 3", obs_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [63:0] act;
            act = (k < obs_q.size()) ? obs_q[k] : 'x;
            n_cmp++; if (act !== exp_q[k]) begin n_bad++; $display("FAIL midrst_next_flit%0d: got %h want %h", k, act, exp_q[k]); end
        end
    endtask

    task automatic test_max_len();
        gen_words(63);
        send_packet(8'h7E, 6'd63, 2, 80, 0);
        n_cmp++; if (obs_q.size() !== 64) begin n_bad++; $display("FAIL maxlen_count: got %0d want 64", obs_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [63:0] act;
            act = (k < obs_q.size()) ? obs_q[k] : 'x;
            n_cmp++; if (act !== exp_q[k]) begin n_bad++; $display("FAIL maxlen_flit%0d: got %h want %h", k, act, exp_q[k]); end
        end
        if (obs_q.size() == 64) begin
            n_cmp++; if (obs_q[63][45:40] !== 6'd63) begin n_bad++; $display("FAIL maxlen_last_seq: got %0d want 63", obs_q[63][45:40]); end
            n_cmp++; if (obs_q[63][63:62] !== 2'd3) begin n_bad++; $display("FAIL maxlen_last_type: got %0d want 3", obs_q[63][63:62]); end
        end
        n_cmp++; if (rrdy_viol !== 0) begin n_bad++; $display("FAIL maxlen_req_ready_busy: got %0d want 0", rrdy_viol); end
        n_cmp++; if (stab_viol !== 0) begin n_bad++; $display("FAIL maxlen_stable: got %0d want 0", stab_viol); end
        n_cmp++; if (drdy_viol !== 0) begin n_bad++; $display("FAIL maxlen_data_ready: got %0d want 0", drdy_viol); end
    endtask

    task automatic test_random();
        for (int p = 0; p < 20; p++) begin
            int len;
            len = $urandom_range(1, 12);
            gen_words(len);
            send_packet(8'($urandom), 6'(len), 2, 70, 0);
            n_cmp++; if (obs_q.size() !== len + 1) begin n_bad++; $display("FAIL rand_count p%0d: got %0d want %0d", p, obs_q.size(), len + 1); end
            for (int k = 0; k < exp_q.size(); k++) begin
                logic [63:0] act;
                act = (k < obs_q.size()) ? obs_q[k] : 'x;
                n_cmp++; if (act !== exp_q[k]) begin n_bad++; $display("FAIL rand_flit p%0d k%0d: got %h want %h", p, k, act, exp_q[k]); end
            end
            n_cmp++; if (stab_viol !== 0) begin n_bad++; $display("FAIL rand_stable p%0d: got %0d want 0", p, stab_viol); end
        end
    endtask

    initial begin
        rst                = 1'b1;
        bus.node_id        = 8'h01;
        bus.cpu_req_valid  = 1'b0;
        bus.cpu_req_dst    = '0;
        bus.cpu_req_len    = '0;
        bus.cpu_data_valid = 1'b0;
        bus.cpu_data       = '0;
        bus.flit_out_ready = 1'b0;
        model_pkt          = 0;
        test_reset();
        test_len_zero();
        test_basic();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_max_len();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
